// File: rtl/scan_decoder_pkg.sv
// Shared constants and the index-to-one-hot helper for scan_decoder.
package scan_decoder_pkg;
  localparam int MAX_N = 6;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Full-width one-hot; callers slice down to 2^N lines.
  function automatic logic [(2**MAX_N)-1:0] decode(input logic [MAX_N-1:0] i);
    return {{((2**MAX_N)-1){1'b0}}, 1'b1} << i;
  endfunction
endpackage

// File: rtl/tick_gen.sv
// Dwell prescaler: tick fires on the cycle the count has reached dwell.
module tick_gen #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clr,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               tick
);
  logic [DWELL_W-1:0] cnt;

  // >= rather than == so a shrinking dwell cannot strand the count above it.
  assign tick = en && (cnt >= dwell);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= tick ? '0 : cnt + DWELL_W'(1);
  end
endmodule

// File: rtl/scan_decoder.sv
// N-to-2^N registered one-hot decoder with direct and self-timed scan modes.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int N              = 4,
  parameter int DWELL_W        = 16,
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               mode,
  input  logic [N-1:0]       code,
  input  logic [DWELL_W-1:0] dwell,
  output logic [(2**N)-1:0]  bcode,
  output logic [N-1:0]       idx,
  output logic               wrap
);
  localparam int OUT_W = 2**N;

  logic                   scan_go, clr, tick, wrap_nxt;
  logic [N-1:0]           idx_nxt;
  logic [(2**MAX_N)-1:0]  dec_full;
  logic [OUT_W-1:0]       sel;

  assign scan_go = en && (mode == MODE_SCAN);
  assign clr     = en && (mode == MODE_DIRECT);

  tick_gen #(.DWELL_W(DWELL_W)) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr),
    .en     (scan_go),
    .dwell  (dwell),
    .tick   (tick)
  );

  always_comb begin
    idx_nxt = idx;
    if (en) begin
      if (mode == MODE_DIRECT) idx_nxt = code;
      else if (tick)           idx_nxt = idx + N'(1);
    end
  end

  assign wrap_nxt = tick && (idx == {N{1'b1}});

  // Decode the next index so bcode and idx update on the same edge.
  assign dec_full = decode(MAX_N'(idx_nxt));
  assign sel      = en ? dec_full[OUT_W-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx   <= '0;
      wrap  <= 1'b0;
      bcode <= OUT_ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    end else begin
      idx   <= idx_nxt;
      wrap  <= wrap_nxt;
      bcode <= OUT_ACTIVE_LOW ? ~sel : sel;
    end
  end
endmodule

// File: tb/tb_scan_decoder.sv
// Randomised and directed bench for scan_decoder against a behavioural model.
module tb_scan_decoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, active-high
  logic        rst_a, en_a, mode_a, wrap_a;
  logic [3:0]  code_a, idx_a;
  logic [15:0] dwell_a, bcode_a;
  // Instance B: N=3, active-low
  logic        rst_b, en_b, mode_b, wrap_b;
  logic [2:0]  code_b, idx_b;
  logic [15:0] dwell_b;
  logic [7:0]  bcode_b;

  scan_decoder #(.N(4), .DWELL_W(16), .OUT_ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .reset_n(rst_a), .en(en_a), .mode(mode_a), .code(code_a),
    .dwell(dwell_a), .bcode(bcode_a), .idx(idx_a), .wrap(wrap_a));

  scan_decoder #(.N(3), .DWELL_W(16), .OUT_ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .reset_n(rst_b), .en(en_b), .mode(mode_b), .code(code_b),
    .dwell(dwell_b), .bcode(bcode_b), .idx(idx_b), .wrap(wrap_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state for instance A: which line is selected and cycles spent on it.
  int m_idx = 0, m_cnt = 0, cycle_no = 0;
  bit m_wrap = 0, m_on = 0;
  int wrap_log[$];

  task automatic cyc();
    @(posedge clk);
    if (en_a) begin
      if (mode_a == 1'b0) begin
        m_idx = int'(code_a); m_cnt = 0; m_wrap = 0;
      end else if (m_cnt >= int'(dwell_a)) begin
        m_wrap = (m_idx == 15);
        m_idx  = (m_idx + 1) % 16;
        m_cnt  = 0;
      end else begin
        m_cnt++; m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
    m_on = en_a;
    cycle_no++;
    #1;
    chk("a_idx", 64'(idx_a), 64'(m_idx));
    chk("a_bcode", 64'(bcode_a), m_on ? (64'd1 << m_idx) : 64'd0);
    chk("a_wrap", 64'(wrap_a), 64'(m_wrap));
    chk("a_onehot", 64'($countones(bcode_a) <= 1), 64'd1);
    if (wrap_a) wrap_log.push_back(cycle_no);
  endtask

  initial begin
    int prev;
    rst_a = 0; en_a = 1; mode_a = 1; code_a = 0; dwell_a = 0;
    rst_b = 0; en_b = 1; mode_b = 1; code_b = 0; dwell_b = 0;
    #12;
    chk("rst_bcode", 64'(bcode_a), 64'h0);
    chk("rst_idx", 64'(idx_a), 64'h0);
    chk("rst_wrap", 64'(wrap_a), 64'h0);
    chk("rst_b_bcode", 64'(bcode_b), 64'hFF);

    mode_a = 0; code_a = 0;
    rst_a = 1;
    cyc();

    // Direct sweep
    for (int i = 0; i < 16; i++) begin
      code_a = 4'(i);
      cyc();
      chk("sweep_bcode", 64'(bcode_a), 64'd1 << i);
    end

    // Scan with dwell=2 from idx 0
    code_a = 0; cyc();
    mode_a = 1; dwell_a = 2;
    wrap_log.delete();
    for (int i = 0; i < 110; i++) cyc();
    chk("wrap_count", 64'(wrap_log.size() >= 2), 64'd1);
    if (wrap_log.size() >= 2) chk("wrap_period", 64'(wrap_log[1] - wrap_log[0]), 64'd48);

    // dwell=0, then shrink from 100 to 10 after 50 cycles
    dwell_a = 0;
    for (int i = 0; i < 20; i++) cyc();
    dwell_a = 100;
    for (int i = 0; i < 50; i++) cyc();
    prev = m_idx;
    dwell_a = 10;
    cyc();
    chk("shrink_adv", 64'(idx_a), 64'((prev + 1) % 16));

    // en and mode transitions
    mode_a = 0; code_a = 5; cyc();
    mode_a = 1; dwell_a = 100;
    repeat (3) cyc();
    en_a = 0; cyc();
    chk("en0_bcode", 64'(bcode_a), 64'h0);
    chk("en0_idx", 64'(idx_a), 64'd5);
    en_a = 1; cyc();
    chk("en1_bcode", 64'(bcode_a), 64'h20);
    mode_a = 0; code_a = 9; cyc();
    chk("to_direct_idx", 64'(idx_a), 64'd9);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      en_a   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) mode_a = ~mode_a;
      if ($urandom_range(0, 15) == 0) dwell_a = 16'($urandom_range(0, 3));
      code_a = 4'($urandom_range(0, 15));
      cyc();
    end

    // Active-low instance
    en_b = 1; mode_b = 0; code_b = 2;
    rst_b = 1;
    @(posedge clk); #1;
    chk("b_direct", 64'(bcode_b), 64'hFB);
    chk("b_idx", 64'(idx_b), 64'd2);
    mode_b = 1; dwell_b = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("b_scan_idx", 64'(idx_b), 64'd5);
    chk("b_scan_bcode", 64'(bcode_b), 64'hDF);
    rst_b = 0;
    #2;
    chk("b_async_bcode", 64'(bcode_b), 64'hFF);
    chk("b_async_idx", 64'(idx_b), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
